// File: rtl/kmap_sweep_ctrl.sv
// Exhaustive truth-table sweeper for an N-input combinational function unit.
// Walks x_out over every code, samples f_in after SETTLE cycles and grades the table against cared entries.
module kmap_sweep_ctrl #(
    parameter int N      = 4,
    parameter int SETTLE = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [(1<<N)-1:0]     care_mask,
    input  logic [(1<<N)-1:0]     expect_tbl,
    output logic [N-1:0]          x_out,
    input  logic                  f_in,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [N-1:0]          fail_idx,
    output logic [N:0]            mismatch_cnt,
    output logic [(1<<N)-1:0]     captured_tbl,
    output logic [1:0]            dbg_state
);

    localparam int DEPTH = 1 << N;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SWEEP = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [3:0]   SETTLE_C = 4'(SETTLE);
    localparam logic [N-1:0] LAST_IDX = {N{1'b1}};
    localparam logic [N-1:0] IDX_ONE  = 1;
    localparam logic [N:0]   CNT_ONE  = 1;

    logic [1:0]       state_q, state_d;
    logic [N-1:0]     idx_q, idx_d;
    logic [3:0]       wait_cnt_q, wait_cnt_d;
    logic [DEPTH-1:0] care_q, care_d;
    logic [DEPTH-1:0] exp_q, exp_d;
    logic [DEPTH-1:0] tbl_q, tbl_d;
    logic [N:0]       cnt_q, cnt_d;
    logic [N-1:0]     first_idx_q, first_idx_d;
    logic             first_vld_q, first_vld_d;
    logic             pass_q, pass_d;
    logic [N-1:0]     fail_idx_q, fail_idx_d;
    logic [N:0]       res_cnt_q, res_cnt_d;
    logic [DEPTH-1:0] cap_q, cap_d;

    logic             f_known;
    logic             f_bit;
    logic             mism;
    logic [N:0]       cnt_inc;

    // An unknown f_in is stored as 0 but always graded as a mismatch on cared codes.
    always_comb begin
        f_known = (f_in === 1'b0) || (f_in === 1'b1);
        f_bit   = (f_in === 1'b1);
        mism    = care_q[idx_q] && (!f_known || (f_bit != exp_q[idx_q]));
        cnt_inc = mism ? (cnt_q + CNT_ONE) : cnt_q;
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wait_cnt_d  = wait_cnt_q;
        care_d      = care_q;
        exp_d       = exp_q;
        tbl_d       = tbl_q;
        cnt_d       = cnt_q;
        first_idx_d = first_idx_q;
        first_vld_d = first_vld_q;
        pass_d      = pass_q;
        fail_idx_d  = fail_idx_q;
        res_cnt_d   = res_cnt_q;
        cap_d       = cap_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_SWEEP;
                    idx_d       = '0;
                    wait_cnt_d  = '0;
                    care_d      = care_mask;
                    exp_d       = expect_tbl;
                    tbl_d       = '0;
                    cnt_d       = '0;
                    first_idx_d = '0;
                    first_vld_d = 1'b0;
                end
            end
            ST_SWEEP: begin
                if (wait_cnt_q != SETTLE_C) begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end else begin
                    tbl_d[idx_q] = f_bit;
                    cnt_d        = cnt_inc;
                    if (mism && !first_vld_q) begin
                        first_vld_d = 1'b1;
                        first_idx_d = idx_q;
                    end
                    if (idx_q == LAST_IDX) begin
                        // Publish results on the way into DONE so they are valid with the pulse.
                        state_d    = ST_DONE;
                        idx_d      = '0;
                        wait_cnt_d = '0;
                        pass_d     = (cnt_inc == '0);
                        res_cnt_d  = cnt_inc;
                        cap_d      = tbl_d;
                        if (first_vld_q)
                            fail_idx_d = first_idx_q;
                        else if (mism)
                            fail_idx_d = idx_q;
                        else
                            fail_idx_d = '0;
                    end else begin
                        idx_d      = idx_q + IDX_ONE;
                        wait_cnt_d = '0;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            wait_cnt_q  <= '0;
            care_q      <= '0;
            exp_q       <= '0;
            tbl_q       <= '0;
            cnt_q       <= '0;
            first_idx_q <= '0;
            first_vld_q <= 1'b0;
            pass_q      <= 1'b0;
            fail_idx_q  <= '0;
            res_cnt_q   <= '0;
            cap_q       <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            wait_cnt_q  <= wait_cnt_d;
            care_q      <= care_d;
            exp_q       <= exp_d;
            tbl_q       <= tbl_d;
            cnt_q       <= cnt_d;
            first_idx_q <= first_idx_d;
            first_vld_q <= first_vld_d;
            pass_q      <= pass_d;
            fail_idx_q  <= fail_idx_d;
            res_cnt_q   <= res_cnt_d;
            cap_q       <= cap_d;
        end
    end

    // idx is forced to 0 outside SWEEP, so x_out rests at 0 in IDLE and DONE.
    assign x_out        = idx_q;
    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_DONE);
    assign pass         = pass_q;
    assign fail_idx     = fail_idx_q;
    assign mismatch_cnt = res_cnt_q;
    assign captured_tbl = cap_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_kmap_sweep_ctrl.sv
// Directed bench for kmap_sweep_ctrl: one instance with SETTLE=1 and one with SETTLE=0 share stimulus.
// A small function model drives f_in; expected tables and timing are hand-derived constants.
module tb_kmap_sweep_ctrl;

    localparam logic [15:0] CARE    = 16'h5BD4;
    localparam logic [15:0] EXPV    = 16'h5850;
    localparam logic [15:0] BASE_F  = 16'h7852;  // cared values of EXPV plus ones on don't-cares 1 and 13
    localparam logic [15:0] DC_MASK = 16'hA42B;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic        start;
    logic [15:0] care_mask;
    logic [15:0] expect_tbl;

    logic [3:0]  x1, x0;
    logic        f1, f0;
    logic        busy1, busy0, done1, done0, pass1, pass0;
    logic [3:0]  fail1, fail0;
    logic [4:0]  cnt1, cnt0;
    logic [15:0] cap1, cap0;
    logic [1:0]  st1, st0;

    int checks = 0;
    int errors = 0;
    int mode   = 0;

    logic        prev_pass;
    logic [3:0]  prev_fail;
    logic [4:0]  prev_cnt;
    logic [15:0] prev_cap;

    kmap_sweep_ctrl #(.N(4), .SETTLE(1)) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .care_mask(care_mask), .expect_tbl(expect_tbl),
        .x_out(x1), .f_in(f1), .busy(busy1), .done(done1), .pass(pass1),
        .fail_idx(fail1), .mismatch_cnt(cnt1), .captured_tbl(cap1), .dbg_state(st1)
    );

    kmap_sweep_ctrl #(.N(4), .SETTLE(0)) dut0 (
        .clk(clk), .resetn(resetn), .start(start),
        .care_mask(care_mask), .expect_tbl(expect_tbl),
        .x_out(x0), .f_in(f0), .busy(busy0), .done(done0), .pass(pass0),
        .fail_idx(fail0), .mismatch_cnt(cnt0), .captured_tbl(cap0), .dbg_state(st0)
    );

    // mode 0: nominal, 1: wrong at codes 2 and 11, 2: X on every don't-care code
    function automatic logic model_f(input logic [3:0] x, input int m);
        logic [15:0] base;
        logic [15:0] dc;
        logic        b;
        base = BASE_F;
        dc   = DC_MASK;
        b    = base[x];
        if (m == 1 && (x == 4'd2 || x == 4'd11))
            b = ~b;
        if (m == 2 && dc[x])
            b = 1'bx;
        return b;
    endfunction

    always_comb f1 = model_f(x1, mode);
    always_comb f0 = model_f(x0, mode);

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Called just after the start-accept edge; that edge is cycle 1.
    task automatic sweep_check(input bit hold, input bit chk0, input logic e_pass,
                               input logic [3:0] e_fail, input logic [4:0] e_cnt,
                               input logic [15:0] e_cap);
        for (int k = 1; k <= 33; k++) begin
            if (!hold)
                start = (k == 10 || k == 17);
            if (k == 1) begin
                care_mask  = 16'hFFFF;
                expect_tbl = 16'h0000;
            end
            check("x_out", 32'(x1), (k <= 32) ? 32'((k - 1) / 2) : 32'd0);
            check("done", 32'(done1), 32'(k == 33));
            check("busy", 32'(busy1), 32'd1);
            if (k == 5) begin
                check("held_pass", 32'(pass1), 32'(prev_pass));
                check("held_fail_idx", 32'(fail1), 32'(prev_fail));
                check("held_cnt", 32'(cnt1), 32'(prev_cnt));
                check("held_cap", 32'(cap1), 32'(prev_cap));
            end
            if (chk0) begin
                check("x_out_s0", 32'(x0), (k <= 16) ? 32'(k - 1) : 32'd0);
                check("done_s0", 32'(done0), 32'(k == 17));
                check("busy_s0", 32'(busy0), 32'(k <= 17));
            end
            if (k < 33) begin
                @(posedge clk);
                #1;
            end
        end
        check("pass", 32'(pass1), 32'(e_pass));
        check("fail_idx", 32'(fail1), 32'(e_fail));
        check("mismatch_cnt", 32'(cnt1), 32'(e_cnt));
        check("captured_tbl", 32'(cap1), 32'(e_cap));
        if (chk0) begin
            check("pass_s0", 32'(pass0), 32'(e_pass));
            check("fail_idx_s0", 32'(fail0), 32'(e_fail));
            check("mismatch_cnt_s0", 32'(cnt0), 32'(e_cnt));
            check("captured_tbl_s0", 32'(cap0), 32'(e_cap));
        end
        prev_pass  = e_pass;
        prev_fail  = e_fail;
        prev_cnt   = e_cnt;
        prev_cap   = e_cap;
        care_mask  = CARE;
        expect_tbl = EXPV;
        if (!hold)
            start = 1'b0;
    endtask

    task automatic run_sweep(input int m, input logic e_pass, input logic [3:0] e_fail,
                             input logic [4:0] e_cnt, input logic [15:0] e_cap);
        mode = m;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        sweep_check(1'b0, 1'b1, e_pass, e_fail, e_cnt, e_cap);
        @(posedge clk);
        #1;
        check("idle_busy", 32'(busy1), 32'd0);
        check("idle_done", 32'(done1), 32'd0);
        check("idle_x_out", 32'(x1), 32'd0);
    endtask

    task automatic clear_prev();
        prev_pass = 1'b0;
        prev_fail = '0;
        prev_cnt  = '0;
        prev_cap  = '0;
    endtask

    initial begin
        resetn     = 1'b0;
        start      = 1'b0;
        care_mask  = CARE;
        expect_tbl = EXPV;
        mode       = 0;
        clear_prev();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_done", 32'(done1), 32'd0);
        check("rst_pass", 32'(pass1), 32'd0);
        check("rst_x_out", 32'(x1), 32'd0);
        check("rst_cnt", 32'(cnt1), 32'd0);
        check("rst_cap", 32'(cap1), 32'd0);
        check("rst_fail_idx", 32'(fail1), 32'd0);
        check("rst_busy_s0", 32'(busy0), 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Nominal function, two wrong cared codes, X on don't-cares
        run_sweep(0, 1'b1, 4'd0, 5'd0, 16'h7852);
        run_sweep(1, 1'b0, 4'd2, 5'd2, 16'h7056);
        run_sweep(2, 1'b1, 4'd0, 5'd0, 16'h5850);

        // start held high: one done per sweep, re-accept only from IDLE
        mode = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        sweep_check(1'b1, 1'b0, 1'b1, 4'd0, 5'd0, 16'h7852);
        @(posedge clk);
        #1;
        check("hold_idle_busy", 32'(busy1), 32'd0);
        check("hold_idle_done", 32'(done1), 32'd0);
        @(posedge clk);
        #1;
        check("hold_restart_busy", 32'(busy1), 32'd1);
        check("hold_restart_x_out", 32'(x1), 32'd0);
        sweep_check(1'b0, 1'b0, 1'b1, 4'd0, 5'd0, 16'h7852);
        @(posedge clk);
        #1;
        check("hold_end_busy", 32'(busy1), 32'd0);

        // Reset in the middle of a failing sweep, then a clean sweep
        mode = 1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 40 && x1 != 4'd7; i++) begin
            @(posedge clk);
            #1;
        end
        check("reach_idx7", 32'(x1), 32'd7);
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_busy", 32'(busy1), 32'd0);
        check("midrst_done", 32'(done1), 32'd0);
        check("midrst_x_out", 32'(x1), 32'd0);
        check("midrst_cnt", 32'(cnt1), 32'd0);
        check("midrst_cap", 32'(cap1), 32'd0);
        check("midrst_pass", 32'(pass1), 32'd0);
        check("midrst_fail_idx", 32'(fail1), 32'd0);
        check("midrst_busy_s0", 32'(busy0), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        clear_prev();
        run_sweep(0, 1'b1, 4'd0, 5'd0, 16'h7852);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
